// File: rtl/cpu_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_axi_pkg
//  Purpose : Shared definitions for the CPU SRAM-like to AXI bridge.
//            - read/write FSM state encodings
//            - default AXI IDs for instruction and data traffic
//            - AXI burst/size constants and an SRAM-size to AXI-size helper
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package cpu_axi_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_AR   = 2'd1,
      R_WAIT = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_SEND = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   localparam int INST_ID_DEFAULT = 0;
   localparam int DATA_ID_DEFAULT = 1;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_BYTE  = 3'b000;
   localparam logic [2:0] AXI_SIZE_HALF  = 3'b001;
   localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

   // SRAM size code (0=B,1=H,2=W) maps directly onto AXI log2(bytes).
   function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
      return {1'b0, sram_size};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_write_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : bridge_write_fsm
//  Purpose : Single-outstanding AXI write engine. Latches a store payload on
//            start, drives AW and W together, retires each channel on its own
//            handshake, then waits for B.
//  Ports   : clk, reset            clock, async active-high reset
//            start, req_*          store accepted this cycle + its payload
//            idle, done            engine idle / B handshake this cycle
//            awaddr..awready       AXI write address channel
//            wdata..wready         AXI write data channel
//            bvalid, bready        AXI write response channel
//  Rev     : 1.0  initial release
// ============================================================================
module bridge_write_fsm
   import cpu_axi_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_wdata,
   output logic        idle,
   output logic        done,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   wr_state_e   state_q, state_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [3:0]  strb_q, strb_d;
   logic [31:0] data_q, data_d;

   logic aw_fire;
   logic w_fire;

   assign awvalid = (state_q == W_SEND) & ~aw_done_q;
   assign wvalid  = (state_q == W_SEND) & ~w_done_q;
   assign bready  = (state_q == W_RESP);
   assign aw_fire = awvalid & awready;
   assign w_fire  = wvalid & wready;
   assign idle    = (state_q == W_IDLE);
   assign done    = bready & bvalid;

   assign awaddr  = addr_q;
   assign awsize  = axi_size(size_q);
   assign wdata   = data_q;
   assign wstrb   = strb_q;

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      addr_d    = addr_q;
      size_d    = size_q;
      strb_d    = strb_q;
      data_d    = data_q;
      case (state_q)
         W_IDLE: begin
            if (start) begin
               state_d   = W_SEND;
               addr_d    = req_addr;
               size_d    = req_size;
               strb_d    = req_wstrb;
               data_d    = req_wdata;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         W_SEND: begin
            // AW and W may complete in either order or in the same cycle.
            aw_done_d = aw_done_q | aw_fire;
            w_done_d  = w_done_q | w_fire;
            if (aw_done_d && w_done_d) begin
               state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (bvalid) begin
               state_d = W_IDLE;
            end
         end
         default: state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= W_IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         addr_q    <= 32'd0;
         size_q    <= 2'd0;
         strb_q    <= 4'd0;
         data_q    <= 32'd0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         strb_q    <= strb_d;
         data_q    <= data_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_axi_bridge
//  Purpose : Bridges the CPU instruction and data SRAM-like ports onto one
//            AXI master with one outstanding read and one outstanding write.
//            Data reads win read arbitration over fetches; the data side has
//            at most one transaction in flight, which keeps it ordered.
//  Config  : BRIDGE_RAW_CHECK_EN - when defined, a fetch is held off only if
//            it hits the word of the outstanding store; otherwise any
//            outstanding store holds off fetches.
//  Ports   : clk, reset                      clock, async active-high reset
//            inst_sram_*                     fetch request/response port
//            data_sram_*                     load/store request/response port
//            ar*, r*                         AXI read address / read data
//            aw*, w*, b*                     AXI write address / data / resp
//  Rev     : 1.0  initial release
// ============================================================================
module cpu_axi_bridge
   import cpu_axi_pkg::*;
#(
   parameter int ID_W    = 4,
   parameter int INST_ID = INST_ID_DEFAULT,
   parameter int DATA_ID = DATA_ID_DEFAULT
)(
   input  logic            clk,
   input  logic            reset,
   // instruction port
   input  logic            inst_sram_req,
   input  logic [1:0]      inst_sram_size,
   input  logic [31:0]     inst_sram_addr,
   output logic            inst_sram_addr_ok,
   output logic            inst_sram_data_ok,
   output logic [31:0]     inst_sram_rdata,
   // data port
   input  logic            data_sram_req,
   input  logic            data_sram_wr,
   input  logic [1:0]      data_sram_size,
   input  logic [31:0]     data_sram_addr,
   input  logic [3:0]      data_sram_wstrb,
   input  logic [31:0]     data_sram_wdata,
   output logic            data_sram_addr_ok,
   output logic            data_sram_data_ok,
   output logic [31:0]     data_sram_rdata,
   // AXI read address
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [2:0]      arsize,
   output logic            arvalid,
   input  logic            arready,
   // AXI read data
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready,
   // AXI write address
   output logic [ID_W-1:0] awid,
   output logic [31:0]     awaddr,
   output logic [2:0]      awsize,
   output logic            awvalid,
   input  logic            awready,
   // AXI write data
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb,
   output logic            wvalid,
   input  logic            wready,
   // AXI write response
   input  logic [ID_W-1:0] bid,
   input  logic [1:0]      bresp,
   input  logic            bvalid,
   output logic            bready
);

   localparam logic [ID_W-1:0] INST_ID_W = ID_W'(INST_ID);
   localparam logic [ID_W-1:0] DATA_ID_W = ID_W'(DATA_ID);

   rd_state_e       rd_state_q, rd_state_d;
   logic [ID_W-1:0] arid_q, arid_d;
   logic [31:0]     araddr_q, araddr_d;
   logic [2:0]      arsize_q, arsize_d;
   logic            data_busy_q, data_busy_d;

   logic        w_idle;
   logic        w_done;
   logic        r_idle;
   logic        inst_blocked;
   logic        data_rd_grant;
   logic        data_wr_grant;
   logic        inst_grant;
   logic        rd_fire;
   logic        data_rd_ok;

   // Responses carry no error path; these inputs are intentionally dropped.
   logic unused_resp;
   assign unused_resp = ^{rresp, bresp, bid, rlast};

   // ------------------------------------------------------------------------
   // Fetch hazard against an outstanding store
   // ------------------------------------------------------------------------
`ifdef BRIDGE_RAW_CHECK_EN
   assign inst_blocked = ~w_idle & (inst_sram_addr[31:2] == awaddr[31:2]);
`else
   assign inst_blocked = ~w_idle;
`endif

   // ------------------------------------------------------------------------
   // Arbitration and handshakes
   // ------------------------------------------------------------------------
   assign r_idle        = (rd_state_q == R_IDLE);
   assign data_rd_grant = data_sram_req & ~data_sram_wr & ~data_busy_q & r_idle;
   assign data_wr_grant = data_sram_req &  data_sram_wr & ~data_busy_q & w_idle;
   // A data read that can go this cycle takes the read channel from fetches.
   assign inst_grant    = inst_sram_req & ~inst_blocked & r_idle & ~data_rd_grant;

   assign data_sram_addr_ok = data_rd_grant | data_wr_grant;
   assign inst_sram_addr_ok = inst_grant;

   assign rd_fire           = (rd_state_q == R_WAIT) & rvalid;
   assign inst_sram_data_ok = rd_fire & (rid == INST_ID_W);
   assign data_rd_ok        = rd_fire & (rid == DATA_ID_W);
   assign data_sram_data_ok = data_rd_ok | w_done;
   assign inst_sram_rdata   = rdata;
   assign data_sram_rdata   = rdata;

   assign arid    = arid_q;
   assign araddr  = araddr_q;
   assign arsize  = arsize_q;
   assign arvalid = (rd_state_q == R_AR);
   assign rready  = (rd_state_q == R_WAIT);
   assign awid    = DATA_ID_W;

   // ------------------------------------------------------------------------
   // Read FSM and data-side occupancy
   // ------------------------------------------------------------------------
   always_comb begin
      rd_state_d  = rd_state_q;
      arid_d      = arid_q;
      araddr_d    = araddr_q;
      arsize_d    = arsize_q;
      data_busy_d = data_busy_q;

      case (rd_state_q)
         R_IDLE: begin
            if (data_rd_grant) begin
               rd_state_d = R_AR;
               arid_d     = DATA_ID_W;
               araddr_d   = data_sram_addr;
               arsize_d   = axi_size(data_sram_size);
            end else if (inst_grant) begin
               rd_state_d = R_AR;
               arid_d     = INST_ID_W;
               araddr_d   = inst_sram_addr;
               arsize_d   = axi_size(inst_sram_size);
            end
         end
         R_AR: begin
            if (arready) begin
               rd_state_d = R_WAIT;
            end
         end
         R_WAIT: begin
            if (rvalid) begin
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase

      // One data transaction in flight, whichever channel carries it.
      if (data_sram_addr_ok) begin
         data_busy_d = 1'b1;
      end else if (data_sram_data_ok) begin
         data_busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state_q  <= R_IDLE;
         arid_q      <= '0;
         araddr_q    <= 32'd0;
         arsize_q    <= 3'd0;
         data_busy_q <= 1'b0;
      end else begin
         rd_state_q  <= rd_state_d;
         arid_q      <= arid_d;
         araddr_q    <= araddr_d;
         arsize_q    <= arsize_d;
         data_busy_q <= data_busy_d;
      end
   end

   // ------------------------------------------------------------------------
   // Write engine
   // ------------------------------------------------------------------------
   bridge_write_fsm u_write_fsm (
      .clk       (clk),
      .reset     (reset),
      .start     (data_wr_grant),
      .req_addr  (data_sram_addr),
      .req_size  (data_sram_size),
      .req_wstrb (data_sram_wstrb),
      .req_wdata (data_sram_wdata),
      .idle      (w_idle),
      .done      (w_done),
      .awaddr    (awaddr),
      .awsize    (awsize),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wvalid    (wvalid),
      .wready    (wready),
      .bvalid    (bvalid),
      .bready    (bready)
   );

endmodule
`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cpu_axi_bridge
//  Purpose : Self-checking bench for cpu_axi_bridge. Table of single reads
//            plus hand-written sequences for arbitration, delayed AW, data
//            ordering, fetch vs store hazard and mid-transaction reset.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_axi_bridge;

   localparam int ID_W = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            inst_sram_req = 1'b0;
   logic [1:0]      inst_sram_size = 2'd0;
   logic [31:0]     inst_sram_addr = 32'd0;
   logic            inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0]     inst_sram_rdata;
   logic            data_sram_req = 1'b0;
   logic            data_sram_wr = 1'b0;
   logic [1:0]      data_sram_size = 2'd0;
   logic [31:0]     data_sram_addr = 32'd0;
   logic [3:0]      data_sram_wstrb = 4'd0;
   logic [31:0]     data_sram_wdata = 32'd0;
   logic            data_sram_addr_ok, data_sram_data_ok;
   logic [31:0]     data_sram_rdata;
   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [2:0]      arsize;
   logic            arvalid;
   logic            arready = 1'b0;
   logic [ID_W-1:0] rid = '0;
   logic [31:0]     rdata = 32'd0;
   logic [1:0]      rresp = 2'd0;
   logic            rlast = 1'b1;
   logic            rvalid = 1'b0;
   logic            rready;
   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [2:0]      awsize;
   logic            awvalid;
   logic            awready = 1'b0;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wvalid;
   logic            wready = 1'b0;
   logic [ID_W-1:0] bid = 4'd1;
   logic [1:0]      bresp = 2'd0;
   logic            bvalid = 1'b0;
   logic            bready;

   int checks = 0;
   int failures = 0;
   logic [31:0] mem [logic [31:0]];

   cpu_axi_bridge #(.ID_W(ID_W), .INST_ID(0), .DATA_ID(1)) dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
      .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
      .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_data;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] rval;
      logic [3:0]  exp_id;
      logic [2:0]  exp_size;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here and
   // outputs are sampled #1 later, well away from either edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Complete single read: request cycle T, AR at T+1 with arready, R at T+2.
   task automatic do_read(input string tag, input bit is_data, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] val,
                          input logic [3:0] exp_id, input logic [2:0] exp_size);
      if (is_data) begin
         data_sram_req = 1'b1; data_sram_wr = 1'b0;
         data_sram_addr = addr; data_sram_size = size;
      end else begin
         inst_sram_req = 1'b1; inst_sram_addr = addr; inst_sram_size = size;
      end
      #1;
      chk({tag, " addr_ok"}, is_data ? data_sram_addr_ok : inst_sram_addr_ok, 32'd1);
      chk({tag, " other addr_ok"}, is_data ? inst_sram_addr_ok : data_sram_addr_ok, 32'd0);
      chk({tag, " arvalid early"}, arvalid, 32'd0);
      tick();
      inst_sram_req = 1'b0; data_sram_req = 1'b0; arready = 1'b1;
      #1;
      chk({tag, " arvalid"}, arvalid, 32'd1);
      chk({tag, " araddr"}, araddr, addr);
      chk({tag, " arid"}, arid, exp_id);
      chk({tag, " arsize"}, arsize, exp_size);
      chk({tag, " data_ok early"}, is_data ? data_sram_data_ok : inst_sram_data_ok, 32'd0);
      tick();
      arready = 1'b0; rvalid = 1'b1; rid = exp_id; rdata = val;
      #1;
      chk({tag, " arvalid drop"}, arvalid, 32'd0);
      chk({tag, " rready"}, rready, 32'd1);
      chk({tag, " data_ok"}, is_data ? data_sram_data_ok : inst_sram_data_ok, 32'd1);
      chk({tag, " other data_ok"}, is_data ? inst_sram_data_ok : data_sram_data_ok, 32'd0);
      chk({tag, " rdata"}, is_data ? data_sram_rdata : inst_sram_rdata, val);
      tick();
      rvalid = 1'b0;
      #1;
      chk({tag, " data_ok clear"}, is_data ? data_sram_data_ok : inst_sram_data_ok, 32'd0);
      chk({tag, " rready clear"}, rready, 32'd0);
   endtask

   task automatic store_req(input logic [31:0] addr, input logic [31:0] val);
      data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = addr;
      data_sram_size = 2'd2; data_sram_wstrb = 4'hF; data_sram_wdata = val;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 32'h1C000000, 2'd2, 32'h02800413, 4'd0, 3'b010};
      vecs[1] = '{1'b1, 32'h00001000, 2'd2, 32'h11223344, 4'd1, 3'b010};
      vecs[2] = '{1'b1, 32'h00001003, 2'd0, 32'h000000AB, 4'd1, 3'b000};
      vecs[3] = '{1'b0, 32'h1C000004, 2'd2, 32'h00100093, 4'd0, 3'b010};
      vecs[4] = '{1'b1, 32'h00001002, 2'd1, 32'h0000BEEF, 4'd1, 3'b001};

      // ---------------- reset state ----------------
      tick(); tick();
      chk("rst arvalid", arvalid, 0);
      chk("rst rready", rready, 0);
      chk("rst awvalid", awvalid, 0);
      chk("rst wvalid", wvalid, 0);
      chk("rst bready", bready, 0);
      chk("rst inst data_ok", inst_sram_data_ok, 0);
      chk("rst data data_ok", data_sram_data_ok, 0);
      chk("rst araddr", araddr, 0);
      chk("rst awaddr", awaddr, 0);
      reset = 1'b0;
      tick();

      // ---------------- table of single reads ----------------
      for (int i = 0; i < 5; i++) begin
         do_read($sformatf("vec%0d", i), vecs[i].is_data, vecs[i].addr, vecs[i].size,
                 vecs[i].rval, vecs[i].exp_id, vecs[i].exp_size);
      end

      // ---------------- same-cycle fetch and load ----------------
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000008; inst_sram_size = 2'd2;
      data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h00001000; data_sram_size = 2'd2;
      #1;
      chk("arb data addr_ok", data_sram_addr_ok, 1);
      chk("arb inst addr_ok", inst_sram_addr_ok, 0);
      tick();
      data_sram_req = 1'b0; arready = 1'b1;
      #1;
      chk("arb araddr", araddr, 32'h00001000);
      chk("arb arid", arid, 1);
      chk("arb inst held", inst_sram_addr_ok, 0);
      tick();
      arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h55667788;
      #1;
      chk("arb data data_ok", data_sram_data_ok, 1);
      chk("arb inst data_ok", inst_sram_data_ok, 0);
      chk("arb inst still held", inst_sram_addr_ok, 0);
      tick();
      rvalid = 1'b0;
      inst_sram_req = 1'b0;
      do_read("arb fetch", 1'b0, 32'h1C000008, 2'd2, 32'h00200113, 4'd0, 3'b010);

      // ---------------- store with delayed awready, then ordered load ----------------
      store_req(32'h00002000, 32'hDEADBEEF);
      #1;
      chk("st addr_ok", data_sram_addr_ok, 1);
      tick();
      data_sram_req = 1'b0; awready = 1'b0; wready = 1'b1;
      #1;
      chk("st awvalid c1", awvalid, 1);
      chk("st wvalid c1", wvalid, 1);
      chk("st awaddr", awaddr, 32'h00002000);
      chk("st awsize", awsize, 3'b010);
      chk("st awid", awid, 1);
      chk("st wstrb", wstrb, 4'hF);
      chk("st wdata", wdata, 32'hDEADBEEF);
      if (wvalid && wready) mem[awaddr] = wdata;
      tick();
      wready = 1'b0;
      #1;
      chk("st wvalid c2", wvalid, 0);
      chk("st awvalid c2", awvalid, 1);
      chk("st bready c2", bready, 0);
      tick();
      awready = 1'b1;
      #1;
      chk("st awvalid c3", awvalid, 1);
      tick();
      awready = 1'b0;
      data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h00002000; data_sram_size = 2'd2;
      #1;
      chk("st awvalid c4", awvalid, 0);
      chk("st bready", bready, 1);
      chk("raw load blocked", data_sram_addr_ok, 0);
      tick();
      bvalid = 1'b1;
      #1;
      chk("st data_ok", data_sram_data_ok, 1);
      chk("raw load blocked at b", data_sram_addr_ok, 0);
      tick();
      bvalid = 1'b0;
      #1;
      chk("st bready clear", bready, 0);
      chk("st data_ok clear", data_sram_data_ok, 0);
      chk("raw mem value", mem.exists(32'h00002000) ? mem[32'h00002000] : 32'd0, 32'hDEADBEEF);
      do_read("raw load", 1'b1, 32'h00002000, 2'd2,
              mem.exists(32'h00002000) ? mem[32'h00002000] : 32'd0, 4'd1, 3'b010);

      // ---------------- fetch to other address during outstanding store ----------------
      store_req(32'h00002000, 32'hCAFEF00D);
      #1;
      chk("hz st addr_ok", data_sram_addr_ok, 1);
      tick();
      data_sram_req = 1'b0; awready = 1'b1; wready = 1'b1;
      inst_sram_req = 1'b1; inst_sram_addr = 32'h00003000; inst_sram_size = 2'd2;
      #1;
      chk("hz awvalid", awvalid, 1);
      chk("hz wvalid", wvalid, 1);
`ifdef BRIDGE_RAW_CHECK_EN
      chk("hz fetch addr_ok", inst_sram_addr_ok, 1);
      tick();
      inst_sram_req = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b1;
      #1;
      chk("hz arvalid", arvalid, 1);
      chk("hz araddr", araddr, 32'h00003000);
      chk("hz bready", bready, 1);
      tick();
      arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h12345678; bvalid = 1'b1;
      #1;
      chk("hz inst data_ok", inst_sram_data_ok, 1);
      chk("hz st data_ok", data_sram_data_ok, 1);
      tick();
      rvalid = 1'b0; bvalid = 1'b0;
`else
      chk("hz fetch addr_ok", inst_sram_addr_ok, 0);
      tick();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
      #1;
      chk("hz fetch blocked", inst_sram_addr_ok, 0);
      chk("hz bready", bready, 1);
      chk("hz st data_ok", data_sram_data_ok, 1);
      tick();
      bvalid = 1'b0;
      #1;
      chk("hz fetch released", inst_sram_addr_ok, 1);
      tick();
      inst_sram_req = 1'b0; arready = 1'b1;
      #1;
      chk("hz araddr", araddr, 32'h00003000);
      tick();
      arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h12345678;
      #1;
      chk("hz inst data_ok", inst_sram_data_ok, 1);
      tick();
      rvalid = 1'b0;
`endif

      // ---------------- reset during R_WAIT and W_SEND ----------------
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000010; inst_sram_size = 2'd2;
      store_req(32'h00004000, 32'h0BADF00D);
      #1;
      chk("mr fetch addr_ok", inst_sram_addr_ok, 1);
      chk("mr store addr_ok", data_sram_addr_ok, 1);
      tick();
      inst_sram_req = 1'b0; data_sram_req = 1'b0; arready = 1'b1;
      tick();
      arready = 1'b0;
      #1;
      chk("mr rready before", rready, 1);
      chk("mr awvalid before", awvalid, 1);
      reset = 1'b1; rvalid = 1'b1; rid = 4'd0; rdata = 32'hFFFFFFFF;
      #1;
      chk("mr arvalid", arvalid, 0);
      chk("mr rready", rready, 0);
      chk("mr awvalid", awvalid, 0);
      chk("mr wvalid", wvalid, 0);
      chk("mr bready", bready, 0);
      chk("mr inst data_ok", inst_sram_data_ok, 0);
      chk("mr data data_ok", data_sram_data_ok, 0);
      chk("mr araddr", araddr, 0);
      tick();
      tick();
      reset = 1'b0; rvalid = 1'b0;
      tick();
      do_read("post reset fetch", 1'b0, 32'h1C000000, 2'd2, 32'h02800413, 4'd0, 3'b010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU top's instruction and data SRAM-like ports, between CPU and memory subsystem.
- Converts the two request/addr_ok/data_ok interfaces into one AXI master: one read channel pair (AR/R) and one write channel set (AW/W/B).
- Allows one outstanding read and one outstanding write.
- Arbitrates inst vs data reads and preserves data-side ordering.

Parameters:
ID_W, 4, width of arid/rid/awid/bid
INST_ID, 0, arid used for instruction fetches
DATA_ID, 1, arid/awid used for data accesses

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_sram_req / inst_sram_size / inst_sram_addr  in  1/2/32  fetch request; size 0=B,1=H,2=W
inst_sram_addr_ok / inst_sram_data_ok / inst_sram_rdata  out  1/1/32  request accepted; read data returned
data_sram_req / data_sram_wr / data_sram_size  in  1/1/2  data request; wr=1 store
data_sram_addr / data_sram_wstrb / data_sram_wdata  in  32/4/32  address, byte strobes, store data
data_sram_addr_ok / data_sram_data_ok / data_sram_rdata  out  1/1/32  accept, completion, load data
arid / araddr / arsize / arvalid  out  ID_W/32/3/1  AXI read address
arready  in  1  AXI read address ready
rid / rdata / rresp / rlast / rvalid  in  ID_W/32/2/1/1  AXI read data
rready  out  1  AXI read data ready
awid / awaddr / awsize / awvalid  out  ID_W/32/3/1  AXI write address
awready  in  1  AXI write address ready
wdata / wstrb / wvalid  out  32/4/1  AXI write data (wlast tied 1 by instantiator)
wready  in  1  AXI write data ready
bid / bresp / bvalid  in  ID_W/2/1  AXI write response
bready  out  1  AXI write response ready

Behaviour:
- Single-beat transfers only. arlen/awlen=0, burst=INCR, lock/cache/prot=0 and wlast=1 are tied off by the instantiator, not ports.
- arsize/awsize = {1'b0, size}.
- Reset (asynchronous, active-high): arvalid, rready, awvalid, wvalid, bready, both addr_ok and both data_ok = 0. FSMs return to idle; latched address/data/ID registers = 0.
  - Reset mid-transaction abandons it; the slave is reset together.
- Read FSM R_IDLE -> R_AR -> R_WAIT -> R_IDLE.
  - R_IDLE, candidate present and not blocked: assert the winner's addr_ok (combinational, same cycle as req); latch addr, size and ID; go to R_AR.
  - Arbitration: a data read (data_sram_req & ~data_sram_wr) beats inst_sram_req.
  - R_AR: arvalid=1, held until arready; go to R_WAIT.
  - R_WAIT: rready=1. On rvalid, pulse data_ok for the side whose ID equals rid, driving that side's rdata = rdata combinationally; go to R_IDLE.
  - Earliest next addr_ok is the following cycle; minimum fetch latency is addr_ok at T, arvalid at T+1, data_ok at T+2.
- Write FSM W_IDLE -> W_SEND -> W_RESP -> W_IDLE.
  - On data write accept: latch addr, size, wstrb, wdata.
  - W_SEND: awvalid and wvalid assert together. Each drops independently on its own handshake, tracked by aw_done / w_done. When both are done (same cycle allowed), go to W_RESP.
  - W_RESP: bready=1. On bvalid, data_sram_data_ok=1; go to W_IDLE.
- Data-side ordering: at most one outstanding data transaction (read or write).
  - data_sram_addr_ok = req & ~data_busy & (wr ? W_IDLE : R_IDLE).
  - This guarantees that read-after-write on the data side is ordered and that both data_ok sources never fire together.
- Inst fetch vs pending store: gated per the optional feature.
- rresp/bresp are ignored; no error reporting.
- addr_ok is never asserted without req. A requester holds req and its payload stable until addr_ok.

Optional Feature:
BRIDGE_RAW_CHECK_EN
- Defined: an inst read is blocked only while a write is outstanding and inst_sram_addr[31:2] == latched awaddr[31:2].
- Undefined: an inst read is blocked whenever the write FSM is not W_IDLE.

Decomposition:
- Shared package cpu_axi_pkg holds:
  - read/write FSM state encodings;
  - INST_ID/DATA_ID defaults;
  - AXI burst/size constants.
- One natural sub-module, bridge_write_fsm: the AW/W/B handshake, aw_done/w_done tracking and the write payload registers.
- The read path and arbitration stay in the top of the block.

Test Plan:
- Inst fetch at 0x1C000000, arready=1, rvalid one cycle later with rdata=0x02800413 -> addr_ok T, arvalid/arid=0 T+1, inst_sram_data_ok with rdata=0x02800413 at T+2.
- Same-cycle inst fetch and data load to 0x00001000 -> data_sram_addr_ok=1, inst_sram_addr_ok=0, araddr=0x00001000, arid=1; fetch accepted after rvalid.
- Store size=2, wstrb=0xF, wdata=0xDEADBEEF to 0x2000, awready delayed 3 cycles, wready=1 -> wvalid drops after 1 cycle, awvalid held 3 cycles, bready asserted after both, data_ok on bvalid.
- Load to 0x2000 issued while that store awaits bvalid -> data_sram_addr_ok held 0 until the cycle after bvalid; read returns the new value 0xDEADBEEF from the memory model.
- Fetch to 0x3000 during outstanding store to 0x2000 -> accepted immediately with BRIDGE_RAW_CHECK_EN defined, blocked until the write completes without it.
- Assert reset while in R_WAIT and W_SEND -> all valid/ready/ok outputs 0 immediately; a fresh fetch after release completes normally.
